// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake.
// Optional signed-overflow flag is built only when CSA_OVF_EN is defined.
module csa_pipe_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned GROUP = 8,
  parameter int unsigned PIPE  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             crout,
  output logic             ovf
);

  localparam int unsigned NGRP = WIDTH / GROUP;
  localparam int unsigned GPS  = NGRP / PIPE;
  localparam int unsigned SW   = GPS * GROUP;
  localparam int unsigned LAST = PIPE - 1;

  if ((WIDTH % GROUP) != 0 || PIPE == 0 || PIPE > NGRP || (NGRP % PIPE) != 0) begin : g_bad_cfg
    $error("csa_pipe_adder: illegal WIDTH/GROUP/PIPE combination");
  end

  // Per-stage registers; operands travel with the operation so later slices see the same op
  logic [WIDTH-1:0] a_q     [PIPE];
  logic [WIDTH-1:0] b_q     [PIPE];
  logic [WIDTH-1:0] sum_q   [PIPE];
  logic             carry_q [PIPE];
  logic             valid_q [PIPE];

  logic [WIDTH-1:0] a_in    [PIPE];
  logic [WIDTH-1:0] b_in    [PIPE];
  logic [WIDTH-1:0] ps_in   [PIPE];
  logic             c_in    [PIPE];
  logic [WIDTH-1:0] sum_d   [PIPE];
  logic             carry_d [PIPE];
  logic             valid_d [PIPE];

  logic stall_c;

  assign stall_c   = valid_q[LAST] && !out_ready;
  assign in_ready  = !stall_c;
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign crout     = carry_q[LAST];

  for (genvar s = 0; s < int'(PIPE); s++) begin : g_stage
    logic [GPS:0]  gcarry;
    logic [SW-1:0] slice_sum;

    if (s == 0) begin : g_first
      // Subtraction folds into addition of the inverted operand with a forced carry-in
      assign a_in[s]    = op1;
      assign b_in[s]    = sub ? ~op2 : op2;
      assign c_in[s]    = sub | cin;
      assign ps_in[s]   = '0;
      assign valid_d[s] = in_valid;
    end else begin : g_next
      assign a_in[s]    = a_q[s-1];
      assign b_in[s]    = b_q[s-1];
      assign c_in[s]    = carry_q[s-1];
      assign ps_in[s]   = sum_q[s-1];
      assign valid_d[s] = valid_q[s-1];
    end

    assign gcarry[0] = c_in[s];

    for (genvar g = 0; g < int'(GPS); g++) begin : g_grp
      localparam int LSB = s * int'(SW) + g * int'(GROUP);
      logic [GROUP:0] s0;
      logic [GROUP:0] s1;

      // Both candidate sums are ready before the group carry arrives
      assign s0 = {1'b0, a_in[s][LSB +: GROUP]} + {1'b0, b_in[s][LSB +: GROUP]};
      assign s1 = {1'b0, a_in[s][LSB +: GROUP]} + {1'b0, b_in[s][LSB +: GROUP]}
                  + (GROUP+1)'(1);
      assign slice_sum[g*GROUP +: GROUP] = gcarry[g] ? s1[GROUP-1:0] : s0[GROUP-1:0];
      assign gcarry[g+1] = gcarry[g] ? s1[GROUP] : s0[GROUP];
    end

    // Bits above this slice are still zero, so OR merges the new slice in place
    assign sum_d[s]   = ps_in[s] | (WIDTH'(slice_sum) << (s * int'(SW)));
    assign carry_d[s] = gcarry[GPS];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE; i++) begin
        valid_q[i] <= 1'b0;
        carry_q[i] <= 1'b0;
        sum_q[i]   <= '0;
      end
    end else if (!stall_c) begin
      for (int unsigned i = 0; i < PIPE; i++) begin
        valid_q[i] <= valid_d[i];
        carry_q[i] <= carry_d[i];
        sum_q[i]   <= sum_d[i];
      end
    end
  end

  // Operand delay registers need no reset: they are qualified by valid_q
  always_ff @(posedge clock) begin
    if (!stall_c) begin
      for (int unsigned i = 0; i < PIPE; i++) begin
        a_q[i] <= a_in[i];
        b_q[i] <= b_in[i];
      end
    end
  end

`ifdef CSA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB recovered as a ^ b ^ sum at that bit
  assign ovf_d = (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ sum_d[LAST][WIDTH-1])
                 ^ carry_d[LAST];

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (!stall_c) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed and random checks for csa_pipe_adder in a 64/8/2 and a 32/4/4 configuration.
module tb_csa_pipe_adder;

`ifdef CSA_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        p64_in_valid = 1'b0, p64_in_ready, p64_cin = 1'b0, p64_sub = 1'b0;
  logic [63:0] p64_op1 = '0, p64_op2 = '0, p64_sum;
  logic        p64_out_valid, p64_out_ready = 1'b1, p64_crout, p64_ovf;

  logic        p32_in_valid = 1'b0, p32_in_ready, p32_cin = 1'b0, p32_sub = 1'b0;
  logic [31:0] p32_op1 = '0, p32_op2 = '0, p32_sum;
  logic        p32_out_valid, p32_out_ready = 1'b1, p32_crout, p32_ovf;

  csa_pipe_adder dut64 (
    .clock(clock), .reset(reset),
    .in_valid(p64_in_valid), .in_ready(p64_in_ready),
    .op1(p64_op1), .op2(p64_op2), .cin(p64_cin), .sub(p64_sub),
    .out_valid(p64_out_valid), .out_ready(p64_out_ready),
    .sum(p64_sum), .crout(p64_crout), .ovf(p64_ovf)
  );

  csa_pipe_adder #(.WIDTH(32), .GROUP(4), .PIPE(4)) dut32 (
    .clock(clock), .reset(reset),
    .in_valid(p32_in_valid), .in_ready(p32_in_ready),
    .op1(p32_op1), .op2(p32_op2), .cin(p32_cin), .sub(p32_sub),
    .out_valid(p32_out_valid), .out_ready(p32_out_ready),
    .sum(p32_sum), .crout(p32_crout), .ovf(p32_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] op1;
    logic [63:0] op2;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        crout;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        crout;
    logic        ovf;
  } res32_t;

  function automatic res32_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic c, input logic s);
    logic [31:0] eb;
    logic [32:0] r;
    res32_t      res;
    eb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, eb} + 33'(s ? 1'b1 : c);
    res.sum   = r[31:0];
    res.crout = r[32];
    res.ovf   = OVF_EN && (a[31] == eb[31]) && (r[31] != a[31]);
    return res;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic apply64(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s,
                         output logic [63:0] rs, output logic rc, output logic ro, output int lat);
    @(negedge clock);
    p64_op1 = a; p64_op2 = b; p64_cin = c; p64_sub = s;
    p64_in_valid = 1'b1; p64_out_ready = 1'b1;
    @(negedge clock);
    p64_in_valid = 1'b0;
    lat = 1;
    while (!p64_out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rs = p64_sum; rc = p64_crout; ro = p64_ovf;
  endtask

  task automatic apply32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                         output logic [31:0] rs, output logic rc, output logic ro, output int lat);
    @(negedge clock);
    p32_op1 = a; p32_op2 = b; p32_cin = c; p32_sub = s;
    p32_in_valid = 1'b1; p32_out_ready = 1'b1;
    @(negedge clock);
    p32_in_valid = 1'b0;
    lat = 1;
    while (!p32_out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rs = p32_sum; rc = p32_crout; ro = p32_ovf;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[12];
    logic [63:0] rs;
    logic        rc, ro;
    int          lat;
    logic [31:0] rs32;
    logic [63:0] got[$];
    logic [63:0] held;
    int          first, idx, stall_cycles;
    logic        ok;
    res32_t      exp_q[$];
    res32_t      e;
    int          sent, recv, cyc;

    vecs[0]  = '{64'hF20F_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF50, 1'b0, 1'b0, 64'hF20F_FFFF_FFFF_FF4F, 1'b1, 1'b0};
    vecs[1]  = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3]  = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[5]  = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[6]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[7]  = '{64'hA, 64'hA, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[8]  = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, 1'b0, 64'h0000_0001_0000_0001, 1'b0, 1'b0};
    vecs[9]  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[10] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[11] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_out_valid", 64'(p64_out_valid), 64'd0);
    chk("rst_sum", p64_sum, 64'd0);
    chk("rst_crout", 64'(p64_crout), 64'd0);
    chk("rst_ovf", 64'(p64_ovf), 64'd0);
    chk("rst_out_valid32", 64'(p32_out_valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 64'(p64_in_ready), 64'd1);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      apply64(vecs[i].op1, vecs[i].op2, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d_sum", i), rs, vecs[i].sum);
      chk($sformatf("vec%0d_crout", i), 64'(rc), 64'(vecs[i].crout));
      chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].ovf & OVF_EN));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
    end

    // Back-to-back with a 3-cycle downstream stall after the first result
    first = -1; idx = 0; stall_cycles = 0; held = '0;
    for (int cy = 0; cy < 16; cy++) begin
      @(negedge clock);
      if (p64_out_valid && first < 0) first = cy;
      p64_out_ready = (first >= 0 && cy < first + 3) ? 1'b0 : 1'b1;
      if (idx < 3) begin
        p64_in_valid = 1'b1;
        p64_op1 = 64'(idx + 1); p64_op2 = 64'(idx + 1); p64_cin = 1'b0; p64_sub = 1'b0;
      end else begin
        p64_in_valid = 1'b0;
      end
      #1;
      if (p64_out_valid && !p64_out_ready) begin
        chk($sformatf("stall_in_ready_c%0d", cy), 64'(p64_in_ready), 64'd0);
        if (stall_cycles == 0) held = p64_sum;
        else chk($sformatf("stall_hold_c%0d", cy), p64_sum, held);
        stall_cycles++;
      end
      if (p64_out_valid && p64_out_ready) got.push_back(p64_sum);
      if (p64_in_valid && p64_in_ready) idx++;
    end
    p64_in_valid = 1'b0; p64_out_ready = 1'b1;
    chk("stall_cycles", 64'(stall_cycles), 64'd3);
    chk("stall_held_value", held, 64'd2);
    chk("stall_result_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk($sformatf("stall_result%0d", i), got[i], 64'(2 * (i + 1)));

    // Reset one cycle after an accepted operation discards it
    @(negedge clock);
    p64_op1 = 64'd10; p64_op2 = 64'd20; p64_cin = 1'b0; p64_sub = 1'b0;
    p64_in_valid = 1'b1;
    @(negedge clock);
    p64_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_in_ready", 64'(p64_in_ready), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (p64_out_valid) ok = 1'b0;
      @(negedge clock);
    end
    chk("midrst_no_stale_result", 64'(ok), 64'd1);
    apply64(64'd100, 64'd23, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("midrst_next_sum", rs, 64'd123);
    chk("midrst_next_latency", 64'(lat), 64'd2);

    // Narrow 4-stage configuration: full carry ripple through every group
    apply32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, rs32, rc, ro, lat);
    chk("w32_sum", 64'(rs32), 64'd0);
    chk("w32_crout", 64'(rc), 64'd1);
    chk("w32_ovf", 64'(ro), 64'd0);
    chk("w32_latency", 64'(lat), 64'd4);

    // Random stream with random bubbles and back-pressure against the reference model
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      p32_out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 1000 && $urandom_range(0, 4) != 0) begin
        p32_in_valid = 1'b1;
        p32_op1 = rand_op(); p32_op2 = rand_op();
        p32_cin = 1'($urandom_range(0, 1)); p32_sub = 1'($urandom_range(0, 1));
      end else begin
        p32_in_valid = 1'b0;
      end
      #1;
      if (p32_out_valid && p32_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_result", 64'({p32_sum, p32_crout, p32_ovf}), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rand%0d", recv), 64'({p32_sum, p32_crout, p32_ovf}), 64'(e));
        end
        recv++;
      end
      if (p32_in_valid && p32_in_ready) begin
        exp_q.push_back(model32(p32_op1, p32_op2, p32_cin, p32_sub));
        sent++;
      end
    end
    p32_in_valid = 1'b0; p32_out_ready = 1'b1;
    chk("rand_received", 64'(recv), 64'd1000);
    chk("rand_leftover", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
